// File: rtl/divider_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package divider_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      FINISH = 2'd2
   } state_e;

   // Bits needed for the iteration counter, which counts WIDTH-1 down to 0.
   function automatic int unsigned cnt_width(input int unsigned width);
      return (width < 2) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/divider_fd.sv
// Divider datapath: A/Q/B registers, WIDTH+1-bit trial subtractor and the
// loadable iteration down-counter with zero flag.
module divider_fd
   import divider_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             a_ld,
   input  logic             a_en,
   input  logic             q_ld,
   input  logic             q_en,
   input  logic             cnt_ld,
   input  logic             cnt_en,
   input  logic [WIDTH-1:0] ld_dividend,
   input  logic [WIDTH-1:0] ld_divisor,
   output logic [WIDTH-1:0] q_nxt,
   output logic [WIDTH-1:0] r_nxt,
   output logic             tneg,
   output logic             zero
);

   localparam int unsigned CW = cnt_width(WIDTH);

   logic [WIDTH:0]   a_q, a_d, a_sh, t_c, a_step;
   logic [WIDTH-1:0] q_q, q_d, b_q, b_d, q_step;
   logic [CW-1:0]    cnt_q, cnt_d;

   // One restoring step: shift {A,Q} left, keep the difference if it is non-negative.
   always_comb begin
      a_sh   = {a_q[WIDTH-1:0], q_q[WIDTH-1]};
      t_c    = a_sh - {1'b0, b_q};
      tneg   = t_c[WIDTH];
      a_step = tneg ? a_sh : t_c;
      q_step = {q_q[WIDTH-2:0], ~tneg};
   end

   assign q_nxt = q_step;
   assign r_nxt = a_step[WIDTH-1:0];
   assign zero  = (cnt_q == '0);

   always_comb begin
      a_d   = a_q;
      q_d   = q_q;
      b_d   = b_q;
      cnt_d = cnt_q;
      if (a_ld)
         a_d = '0;
      else if (a_en)
         a_d = a_step;
      if (q_ld) begin
         q_d = ld_dividend;
         b_d = ld_divisor;
      end else if (q_en) begin
         q_d = q_step;
      end
      if (cnt_ld)
         cnt_d = CW'(WIDTH - 1);
      else if (cnt_en)
         cnt_d = cnt_q - CW'(1);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         a_q   <= '0;
         q_q   <= '0;
         b_q   <= '0;
         cnt_q <= '0;
      end else begin
         a_q   <= a_d;
         q_q   <= q_d;
         b_q   <= b_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/divider_seq.sv
// Sequential restoring divider, one quotient bit per clock, with control FSM.
// Define DIVIDER_SIGNED_EN for two's-complement operands (truncating division).
module divider_seq
   import divider_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_zero
);

   state_e state_q, state_d;

   logic a_ld, a_en, q_ld, q_en, cnt_ld, cnt_en;
   logic tneg, zero;
   logic [WIDTH-1:0] ld_dividend, ld_divisor, q_nxt, r_nxt, q_fin, r_fin;

   logic             busy_q, busy_d, done_q, done_d, div_zero_q, div_zero_d;
   logic [WIDTH-1:0] quotient_q, quotient_d, remainder_q, remainder_d;

   logic accept_c, dz_c;
   assign accept_c = (state_q == IDLE) && start;
   assign dz_c     = (divisor == '0);

`ifdef DIVIDER_SIGNED_EN
   logic qneg_q, rneg_q;

   // Iterate on magnitudes; signs are reapplied when the result is captured.
   assign ld_dividend = dividend[WIDTH-1] ? (~dividend + WIDTH'(1)) : dividend;
   assign ld_divisor  = divisor[WIDTH-1]  ? (~divisor + WIDTH'(1))  : divisor;
   assign q_fin       = qneg_q ? (~q_nxt + WIDTH'(1)) : q_nxt;
   assign r_fin       = rneg_q ? (~r_nxt + WIDTH'(1)) : r_nxt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         qneg_q <= 1'b0;
         rneg_q <= 1'b0;
      end else if (q_ld) begin
         qneg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
         rneg_q <= dividend[WIDTH-1];
      end
   end
`else
   assign ld_dividend = dividend;
   assign ld_divisor  = divisor;
   assign q_fin       = q_nxt;
   assign r_fin       = r_nxt;
`endif

   divider_fd #(.WIDTH(WIDTH)) u_fd (
      .clk        (clk),
      .rst        (rst),
      .a_ld       (a_ld),
      .a_en       (a_en),
      .q_ld       (q_ld),
      .q_en       (q_en),
      .cnt_ld     (cnt_ld),
      .cnt_en     (cnt_en),
      .ld_dividend(ld_dividend),
      .ld_divisor (ld_divisor),
      .q_nxt      (q_nxt),
      .r_nxt      (r_nxt),
      .tneg       (tneg),
      .zero       (zero)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = dz_c ? FINISH : RUN;
         RUN:     if (zero) state_d = FINISH;
         FINISH:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath controls and next values of the registered outputs.
   always_comb begin
      a_ld        = 1'b0;
      a_en        = 1'b0;
      q_ld        = 1'b0;
      q_en        = 1'b0;
      cnt_ld      = 1'b0;
      cnt_en      = 1'b0;
      busy_d      = (state_d != IDLE);
      done_d      = (state_d == FINISH);
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      div_zero_d  = div_zero_q;
      case (state_q)
         IDLE: begin
            if (accept_c && !dz_c) begin
               a_ld   = 1'b1;
               q_ld   = 1'b1;
               cnt_ld = 1'b1;
            end else if (accept_c) begin
               quotient_d  = '1;
               remainder_d = dividend;
               div_zero_d  = 1'b1;
            end
         end
         RUN: begin
            a_en   = 1'b1;
            q_en   = 1'b1;
            cnt_en = 1'b1;
            if (zero) begin
               quotient_d  = q_fin;
               remainder_d = r_fin;
               div_zero_d  = 1'b0;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         quotient_q  <= '0;
         remainder_q <= '0;
         div_zero_q  <= 1'b0;
      end else begin
         busy_q      <= busy_d;
         done_q      <= done_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         div_zero_q  <= div_zero_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign quotient  = quotient_q;
   assign remainder = remainder_q;
   assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_divider_seq.sv
// Self-checking bench for divider_seq: vector table plus multi-cycle corner sequences.
module tb_divider_seq;

   localparam int unsigned W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] dividend, divisor;
   logic         busy, done, div_zero;
   logic [W-1:0] quotient, remainder;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         dz;
   } vec_t;

   typedef struct {
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         dz;
      int           lat;
   } exp_t;

   vec_t tbl[$];
   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   divider_seq #(.WIDTH(W)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .dividend (dividend),
      .divisor  (divisor),
      .busy     (busy),
      .done     (done),
      .quotient (quotient),
      .remainder(remainder),
      .div_zero (div_zero)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
      end
   endtask

   task automatic add_vec(input logic [W-1:0] a, b, q, r, input logic dz);
      vec_t v;
      v.a = a; v.b = b; v.q = q; v.r = r; v.dz = dz;
      tbl.push_back(v);
   endtask

   // Issues one operation at the next falling edge and follows it to its done pulse.
   // inject pulses start with other operands in cycles 3 and 9 (while busy).
   task automatic run_op(input logic [W-1:0] a, b, q, r, input logic dz, input bit inject);
      exp_t e;
      bit   busy_ok;
      bit   got;
      @(negedge clk);
      start = 1'b1; dividend = a; divisor = b;
      e.q = q; e.r = r; e.dz = dz; e.lat = dz ? 1 : W + 1;
      sb.push_back(e);
      busy_ok = 1'b1;
      got     = 1'b0;
      for (int k = 1; k <= 40 && !got; k++) begin
         @(negedge clk);
         start    = 1'b0;
         dividend = W'($urandom);
         divisor  = W'($urandom);
         if (busy !== 1'b1) busy_ok = 1'b0;
         if (done === 1'b1) begin
            exp_t x;
            got = 1'b1;
            if (sb.size() == 0) begin
               check("scoreboard_empty", 32'd1, 32'd0);
            end else begin
               x = sb.pop_front();
               check("done_latency", k, x.lat);
               check("quotient", quotient, x.q);
               check("remainder", remainder, x.r);
               check("div_zero", div_zero, x.dz);
            end
         end
         if (inject && (k == 3 || k == 9)) begin
            start = 1'b1; dividend = 8'd50; divisor = 8'd5;
         end
      end
      check("busy_during_op", busy_ok, 1);
      if (!got) begin
         check("done_timeout", 0, 1);
         if (sb.size() != 0) void'(sb.pop_front());
      end
   endtask

   initial begin
      bit done_seen;
      rst = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
      #1;
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_quotient", quotient, 0);
      check("reset_remainder", remainder, 0);
      check("reset_div_zero", div_zero, 0);
      repeat (2) @(negedge clk);
      rst = 1'b1;

`ifdef DIVIDER_SIGNED_EN
      add_vec(8'h9C, 8'd7,   8'hF2, 8'hFE, 1'b0);
      add_vec(8'd100, 8'hF9, 8'hF2, 8'h02, 1'b0);
      add_vec(8'h80, 8'hFF,  8'h80, 8'h00, 1'b0);
      add_vec(8'd42, 8'd0,   8'hFF, 8'd42, 1'b1);
      add_vec(8'd42, 8'd6,   8'd7,  8'd0,  1'b0);
      add_vec(8'hFF, 8'd1,   8'hFF, 8'd0,  1'b0);
      add_vec(8'd5,  8'd9,   8'd0,  8'd5,  1'b0);
      add_vec(8'h81, 8'h7F,  8'hFF, 8'd0,  1'b0);
      add_vec(8'h80, 8'd2,   8'hC0, 8'd0,  1'b0);
`else
      add_vec(8'd100, 8'd7,   8'd14,  8'd2,  1'b0);
      add_vec(8'd255, 8'd1,   8'd255, 8'd0,  1'b0);
      add_vec(8'd5,   8'd9,   8'd0,   8'd5,  1'b0);
      add_vec(8'd42,  8'd0,   8'hFF,  8'd42, 1'b1);
      add_vec(8'd42,  8'd6,   8'd7,   8'd0,  1'b0);
      add_vec(8'd0,   8'd5,   8'd0,   8'd0,  1'b0);
      add_vec(8'd7,   8'd7,   8'd1,   8'd0,  1'b0);
      add_vec(8'd255, 8'd255, 8'd1,   8'd0,  1'b0);
      add_vec(8'd1,   8'd255, 8'd0,   8'd1,  1'b0);
      add_vec(8'd128, 8'd16,  8'd8,   8'd0,  1'b0);
      add_vec(8'd0,   8'd0,   8'hFF,  8'd0,  1'b1);
      add_vec(8'd254, 8'd3,   8'd84,  8'd2,  1'b0);
`endif

      for (int i = 0; i < tbl.size(); i++)
         run_op(tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r, tbl[i].dz, 1'b0);

      // Results hold in IDLE; done is a single-cycle pulse.
      repeat (3) begin
         @(negedge clk);
         check("idle_done", done, 0);
         check("idle_busy", busy, 0);
         check("held_quotient", quotient, tbl[tbl.size()-1].q);
      end

      // Starts while busy are ignored; a start in the IDLE cycle after done is accepted.
`ifdef DIVIDER_SIGNED_EN
      run_op(8'd200, 8'd13, 8'hFC, 8'hFC, 1'b0, 1'b1);
`else
      run_op(8'd200, 8'd13, 8'd15, 8'd5, 1'b0, 1'b1);
`endif
      run_op(8'd9, 8'd2, 8'd4, 8'd1, 1'b0, 1'b0);

      // Abort mid-operation with reset after a divide-by-zero left non-zero outputs.
      run_op(8'd42, 8'd0, 8'hFF, 8'd42, 1'b1, 1'b0);
      @(negedge clk);
      start = 1'b1; dividend = 8'd100; divisor = 8'd7;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_quotient", quotient, 0);
      check("abort_remainder", remainder, 0);
      check("abort_div_zero", div_zero, 0);
      done_seen = 1'b0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (k == 2) rst = 1'b1;
         if (done === 1'b1) done_seen = 1'b1;
      end
      check("abort_no_done", done_seen, 0);
      check("abort_quotient_held", quotient, 0);
      run_op(8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 1'b0);

      check("scoreboard_drained", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/divider_seq.md
Name: divider_seq

Overview:
- Sequential unsigned restoring divider using shift-subtract, one quotient bit per clock.
- It is the inverse of the team's shift-add multiplier and uses the same split: datapath registers A/Q/B, a down-counter with a zero flag, and a small control FSM.
- Used by arithmetic units that need quotient and remainder of WIDTH-bit operands.

Parameters:
- WIDTH, 8: operand, quotient and remainder width; must be at least 2.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-low (asserted at 0)
- start  input  1  request; sampled only in IDLE
- dividend  input  WIDTH  captured on the accepted start
- divisor  input  WIDTH  captured on the accepted start
- busy  output  1  high from the cycle after an accepted start through the FINISH cycle
- done  output  1  one-cycle pulse; results are valid from this cycle on
- quotient  output  WIDTH  registered; held until the next accepted start
- remainder  output  WIDTH  registered; held until the next accepted start
- div_zero  output  1  registered; set when the last operation had divisor==0

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; busy=0, done=0, quotient=0, remainder=0, div_zero=0; counter=0.
- Reset mid-operation: the operation is aborted immediately. No done pulse is issued, and outputs take the reset values.
- States and transitions:
  - IDLE -> RUN: start=1 and divisor!=0. Load A=0 (WIDTH+1 bits), Q=dividend, B=divisor, counter=WIDTH-1.
  - IDLE -> FINISH: start=1 and divisor==0. Division-by-zero path.
  - RUN: each cycle, shift {A,Q} left by 1 and compute T=A-{0,B} (WIDTH+1 bits).
    - If T[WIDTH]==0: A=T and Q[0]=1.
    - Otherwise: A is unchanged (shifted value) and Q[0]=0.
  - RUN: the counter decrements each cycle. On the cycle where counter==0, the last iteration completes and the FSM goes to FINISH.
  - FINISH: done=1, busy=1 for this one cycle; then -> IDLE.
- Output update: quotient/remainder/div_zero are written on the edge entering FINISH, so they are valid while done=1. They are cleared only by reset.
- Latency: call the cycle where start is accepted cycle 0.
  - RUN occupies cycles 1..WIDTH; done=1 in cycle WIDTH+1.
  - Divide-by-zero: done=1 in cycle 1.
- Divide-by-zero result: quotient={WIDTH{1}}, remainder=dividend, div_zero=1. For a normal operation div_zero=0.
- start while busy (RUN or FINISH) is ignored; it is neither queued nor restarting.
- Back-to-back: start is accepted in the IDLE cycle right after FINISH. Minimum issue interval is WIDTH+2 cycles.
- Operands are captured only at acceptance; later input changes have no effect.
- Arithmetic: all operands unsigned. Remainder is always < divisor. Result satisfies dividend = quotient*divisor + remainder.

Optional Feature:
- Macro DIVIDER_SIGNED_EN, defined: operands are two's complement.
  - At acceptance, the magnitudes are loaded.
  - On entry to FINISH: quotient is negated if the operand signs differ; remainder takes the dividend's sign (truncation toward zero).
  - Overflow (most-negative / -1): quotient = most-negative (wraps), remainder = 0, div_zero=0.
  - Divide-by-zero: quotient = all ones, remainder = dividend.
  - Latency is unchanged.
- Macro undefined: pure unsigned behaviour as above, with no sign logic synthesized.

Decomposition:
- Package divider_pkg:
  - state typedef {IDLE, RUN, FINISH}
  - function for counter width = $clog2(WIDTH)
- Sub-module divider_fd: datapath holding the A/Q/B registers, the WIDTH+1-bit subtractor, and the loadable down-counter with zero flag. Control signals are a_ld, a_en, q_ld, q_en, cnt_ld, cnt_en; status outputs are tneg and zero.
- FSM lives in divider_seq.

Test Plan:
- 100/7, WIDTH=8 -> quotient=14, remainder=2, done exactly at cycle 9, busy high cycles 1-9.
- 255/1 and 5/9 -> (255,0) and (0,5); div_zero=0.
- 42/0 -> done at cycle 1, quotient=0xFF, remainder=42, div_zero=1; a following 42/6 -> (7,0) with div_zero=0.
- start pulsed at cycles 3 and 9 of a 200/13 run -> ignored; result (15,5); a start in the IDLE cycle after done is accepted.
- rst=0 at cycle 4 of 100/7 -> outputs immediately 0, no done pulse; a new start after release gives the correct result.
- With DIVIDER_SIGNED_EN:
  - -100/7 -> quotient=0xF2 (-14), remainder=0xFE (-2).
  - 100/-7 -> (-14, 2).
  - -128/-1 -> quotient=0x80, remainder=0.
